// File: rtl/led_pattern_ctrl_pkg.sv
// Shared mode encoding, pattern lengths and the per-phase LED lookup for
// the multi-channel LED pattern driver.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_ON     = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_DFLASH = 2'd3
    } mode_e;

    localparam int         BLINK_LEN   = 2;
    localparam int         DFLASH_LEN  = 6;
    localparam logic [5:0] DFLASH_MASK = 6'b000101;

    // Index of the last phase of a running pattern; pi wraps to 0 after it.
    function automatic logic [2:0] pattern_last(input mode_e m);
        pattern_last = (m == MODE_DFLASH) ? 3'(DFLASH_LEN - 1) : 3'(BLINK_LEN - 1);
    endfunction

    function automatic logic pattern_runs(input mode_e m);
        pattern_runs = (m == MODE_BLINK) || (m == MODE_DFLASH);
    endfunction

    function automatic logic pattern_bit(input mode_e m, input logic [2:0] pi);
        unique case (m)
            MODE_OFF:    pattern_bit = 1'b0;
            MODE_ON:     pattern_bit = 1'b1;
            MODE_BLINK:  pattern_bit = (pi == 3'd0);
            MODE_DFLASH: pattern_bit = (pi < 3'(DFLASH_LEN)) && DFLASH_MASK[pi];
            default:     pattern_bit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Board-side bundle: switches and per-channel config in, LED pins and tick out.
interface led_pattern_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int RATE_W = 10
);
    logic [NUM_CH-1:0]        sw;
    logic [2*NUM_CH-1:0]      mode;
    logic [RATE_W*NUM_CH-1:0] half_period;
    logic [NUM_CH-1:0]        led;
    logic                     tick;

    modport master (output sw, mode, half_period, input led, tick);
    modport slave  (input sw, mode, half_period, output led, tick);
endinterface

// File: rtl/led_pattern_ctrl_channel.sv
// One LED channel: switch synchroniser and debouncer, phase counter,
// pattern index and registered LED output.
module led_channel
    import led_pkg::*;
#(
    parameter int RATE_W    = 10,
    parameter int DEB_TICKS = 20
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic              tick_i,
    input  logic              sw_i,
    input  logic [1:0]        mode_i,
    input  logic [RATE_W-1:0] half_period_i,
    output logic              led_o
);
    localparam int DEB_W = $clog2(DEB_TICKS + 1);

    logic              sync1_q, sync2_q;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              en_q, en_d;
    mode_e             mode_prev_q, mode_cur;
    logic [RATE_W-1:0] pc_q, pc_d, hp;
    logic [2:0]        pi_q, pi_d;
    logic              led_q, led_d;

    assign mode_cur = mode_e'(mode_i);

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        en_d      = en_q;
        pc_d      = pc_q;
        pi_d      = pi_q;
        hp        = (half_period_i == '0) ? RATE_W'(1) : half_period_i;

        if (sync2_q == en_q) begin
            deb_cnt_d = '0;
        end else if (tick_i) begin
            if (deb_cnt_q == DEB_W'(DEB_TICKS - 1)) begin
                en_d      = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        // A mode change restarts the new pattern from its first phase.
        if (!en_q || (mode_cur != mode_prev_q) || !pattern_runs(mode_cur)) begin
            pc_d = '0;
            pi_d = '0;
        end else if (tick_i) begin
            if (pc_q >= hp - 1'b1) begin
                pc_d = '0;
                pi_d = (pi_q >= pattern_last(mode_cur)) ? 3'd0 : pi_q + 3'd1;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end

        led_d = en_q & pattern_bit(mode_prev_q, pi_q);
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            deb_cnt_q   <= '0;
            en_q        <= 1'b0;
            mode_prev_q <= MODE_OFF;
            pc_q        <= '0;
            pi_q        <= '0;
            led_q       <= 1'b0;
        end else begin
            sync1_q     <= sw_i;
            sync2_q     <= sync1_q;
            deb_cnt_q   <= deb_cnt_d;
            en_q        <= en_d;
            mode_prev_q <= mode_cur;
            pc_q        <= pc_d;
            pi_q        <= pi_d;
            led_q       <= led_d;
        end
    end

    assign led_o = led_q;
endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern driver: shared tick prescaler feeding
// NUM_CH independent channel engines.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int TICK_DIV  = 125000,
    parameter int RATE_W    = 10,
    parameter int DEB_TICKS = 20
) (
    input  logic          sysclk,
    input  logic          rst_n,
    led_pattern_ctrl_if.slave bus
);
    localparam int PS_W = $clog2(TICK_DIV);

    logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
    logic              tick_q, tick_d;
    logic [NUM_CH-1:0] led_w;

    always_comb begin
        tick_d   = (ps_cnt_q == PS_W'(TICK_DIV - 1));
        ps_cnt_d = tick_d ? '0 : ps_cnt_q + 1'b1;
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
            tick_q   <= tick_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            led_channel #(
                .RATE_W    (RATE_W),
                .DEB_TICKS (DEB_TICKS)
            ) u_ch (
                .sysclk        (sysclk),
                .rst_n         (rst_n),
                .tick_i        (tick_q),
                .sw_i          (bus.sw[gi]),
                .mode_i        (bus.mode[2*gi +: 2]),
                .half_period_i (bus.half_period[RATE_W*gi +: RATE_W]),
                .led_o         (led_w[gi])
            );
        end
    endgenerate

    assign bus.led  = led_w;
    assign bus.tick = tick_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl against a timeline reference model.
module tb_led_pattern_ctrl;
    localparam int NCH  = 2;
    localparam int TDIV = 4;
    localparam int RW   = 4;
    localparam int DEB  = 3;

    logic sysclk = 1'b0;
    logic rst_n  = 1'b0;
    always #5 sysclk = ~sysclk;

    led_pattern_ctrl_if #(.NUM_CH(NCH), .RATE_W(RW)) ifc ();

    led_pattern_ctrl #(
        .NUM_CH    (NCH),
        .TICK_DIV  (TDIV),
        .RATE_W    (RW),
        .DEB_TICKS (DEB)
    ) dut (
        .sysclk (sysclk),
        .rst_n  (rst_n),
        .bus    (ifc)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: time measured in edges since reset release.
    int m_n;
    int m_s1 [NCH], m_s2 [NCH], m_en [NCH], m_dc [NCH];
    int m_pm [NCH], m_pc [NCH], m_pi [NCH], m_led [NCH];
    int blink_tab  [2] = '{1, 0};
    int dflash_tab [6] = '{1, 0, 1, 0, 0, 0};

    function automatic int level(input int md, input int ph);
        case (md)
            1:       return 1;
            2:       return blink_tab[ph % 2];
            3:       return dflash_tab[ph % 6];
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_n = 0;
        for (int c = 0; c < NCH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_en[c] = 0; m_dc[c] = 0;
            m_pm[c] = 0; m_pc[c] = 0; m_pi[c] = 0; m_led[c] = 0;
        end
    endtask

    task automatic model_edge();
        int tick_seen, md, hpv, plen;
        tick_seen = (m_n > 0 && m_n % TDIV == 0) ? 1 : 0;
        for (int c = 0; c < NCH; c++) begin
            md   = int'(ifc.mode[2*c +: 2]);
            hpv  = int'(ifc.half_period[RW*c +: RW]);
            if (hpv == 0) hpv = 1;
            plen = (md == 3) ? 6 : 2;
            m_led[c] = (m_en[c] != 0) ? level(m_pm[c], m_pi[c]) : 0;
            if (m_en[c] == 0 || md != m_pm[c] || md < 2) begin
                m_pc[c] = 0;
                m_pi[c] = 0;
            end else if (tick_seen != 0) begin
                if (m_pc[c] + 1 >= hpv) begin
                    m_pc[c] = 0;
                    m_pi[c] = (m_pi[c] + 1) % plen;
                end else begin
                    m_pc[c]++;
                end
            end
            if (m_s2[c] == m_en[c]) m_dc[c] = 0;
            else if (tick_seen != 0) begin
                m_dc[c]++;
                if (m_dc[c] == DEB) begin
                    m_en[c] = m_s2[c];
                    m_dc[c] = 0;
                end
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = int'(ifc.sw[c]);
            m_pm[c] = md;
        end
        m_n++;
    endtask

    function automatic logic [NCH-1:0] exp_led();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = (m_led[c] != 0);
        return v;
    endfunction

    function automatic logic exp_tick();
        return (m_n > 0 && m_n % TDIV == 0);
    endfunction

    task automatic check_outputs();
        logic [NCH-1:0] el;
        logic           et;
        el = exp_led();
        et = exp_tick();
        tests++;
        assert (ifc.led === el) else begin
            fails++;
            $error("FAIL led cyc=%0d observed=%b expected=%b", cyc, ifc.led, el);
        end
        tests++;
        assert (ifc.tick === et) else begin
            fails++;
            $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, ifc.tick, et);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sysclk);
            if (!rst_n) model_reset();
            else        model_edge();
            cyc++;
            #1;
            check_outputs();
        end
    endtask

    task automatic set_ch(input int c, input int swv, input int md, input int hpv);
        ifc.sw[c]                 = 1'(swv);
        ifc.mode[2*c +: 2]        = 2'(md);
        ifc.half_period[RW*c +: RW] = RW'(hpv);
    endtask

    initial begin
        int guard;
        ifc.sw          = '0;
        ifc.mode        = '0;
        ifc.half_period = '0;
        model_reset();

        // Reset held for 5 cycles, then free running with tick every TDIV.
        step(5);
        rst_n = 1'b1;
        step(12);
        $display("[TB] reset/prescaler done cyc=%0d", cyc);

        // Short switch pulse (2 ticks) must not enable ch0.
        set_ch(0, 1, 1, 3);
        step(2 * TDIV);
        set_ch(0, 0, 1, 3);
        step(30);
        tests++;
        assert (ifc.led[0] === 1'b0) else begin
            fails++;
            $error("FAIL glitch_en observed=%b expected=0", ifc.led[0]);
        end
        set_ch(0, 1, 1, 3);
        step(30);
        tests++;
        assert (ifc.led[0] === 1'b1) else begin
            fails++;
            $error("FAIL debounce_on observed=%b expected=1", ifc.led[0]);
        end
        $display("[TB] debounce done cyc=%0d", cyc);

        // BLINK, then half_period 0 treated as 1.
        set_ch(0, 1, 2, 3);
        step(60);
        set_ch(0, 1, 2, 0);
        step(20);
        $display("[TB] blink done cyc=%0d", cyc);

        // DFLASH on ch1.
        set_ch(1, 1, 3, 2);
        step(30 + 100);
        $display("[TB] dflash done cyc=%0d", cyc);

        // Mode change during the BLINK off phase.
        set_ch(0, 1, 2, 3);
        step(2);
        guard = 0;
        while (!(m_pi[0] == 1 && m_pm[0] == 2) && guard < 200) begin
            step(1);
            guard++;
        end
        tests++;
        assert (guard < 200) else begin
            fails++;
            $error("FAIL blink_off_wait observed=%0d expected<200", guard);
        end
        set_ch(0, 1, 3, 3);
        step(2);
        tests++;
        assert (ifc.led[0] === 1'b1) else begin
            fails++;
            $error("FAIL modechg_led observed=%b expected=1", ifc.led[0]);
        end
        step(40);
        $display("[TB] mode change done cyc=%0d", cyc);

        // Async reset while both LEDs are on.
        set_ch(0, 1, 1, 3);
        set_ch(1, 1, 1, 2);
        guard = 0;
        while (exp_led() != 2'b11 && guard < 200) begin
            step(1);
            guard++;
        end
        tests++;
        assert (ifc.led === 2'b11) else begin
            fails++;
            $error("FAIL both_on observed=%b expected=11", ifc.led);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        assert (ifc.led === 2'b00) else begin
            fails++;
            $error("FAIL async_rst observed=%b expected=00", ifc.led);
        end
        step(3);
        rst_n = 1'b1;
        step(40);
        $display("[TB] async reset done cyc=%0d", cyc);

        // Randomised segments against the model.
        for (int seg = 0; seg < 60; seg++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 2) != 0)
                    set_ch(c, int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 5)));
            end
            step(int'($urandom_range(1, 40)));
            $display("[TB] random seg=%0d cyc=%0d led=%b", seg, cyc, ifc.led);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
